// File: rtl/vec_alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality check
// for the vec_alu_pipe slice.
package vec_alu_pkg;

  localparam logic [3:0] OP_OR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XORS = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;
  localparam logic [3:0] OP_ADDS = 4'b1010;
  localparam logic [3:0] OP_SUBS = 4'b1011;
  localparam logic [3:0] OP_OFFS = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_OR, OP_ADD, OP_SUB, OP_XORS, OP_SHL, OP_SHR,
      OP_ROL, OP_ROR, OP_ADDS, OP_SUBS, OP_OFFS: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vec_alu_pipe_alu_lane.sv
// Combinational single-lane ALU: vector-vector and vector-scalar ops on one
// DATA_W-bit element; unknown opcodes produce zero.
module alu_lane
  import vec_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W:0] W_V = (DATA_W + 1)'(DATA_W);

  logic                  shift_big;
  logic [DATA_W-1:0]     rot;
  logic [2*DATA_W-1:0]   dbl_l;
  logic [2*DATA_W-1:0]   dbl_r;

  // Rotates shift a doubled copy so the wrapped bits come along for free;
  // rot == 0 naturally returns a unchanged.
  always_comb begin
    shift_big = ({1'b0, s} >= W_V);
    rot       = DATA_W'({1'b0, s} % W_V);
    dbl_l     = {a, a} << rot;
    dbl_r     = {a, a} >> rot;
  end

  always_comb begin
    y = '0;
    case (op)
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_XORS: y = a ^ s;
      OP_SHL:  y = shift_big ? '0 : (a << s);
      OP_SHR:  y = shift_big ? '0 : (a >> s);
      OP_ROL:  y = dbl_l[2*DATA_W-1:DATA_W];
      OP_ROR:  y = dbl_r[DATA_W-1:0];
      OP_ADDS: y = a + s;
      OP_SUBS: y = a - s;
      OP_OFFS: y = a + s;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// Multi-beat vector ALU: latches a command, streams LANES-wide operand beats
// through per-lane ALUs into a registered, back-pressurable result stage.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int MAXBEATS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [3:0]                        opcode,
  input  logic [DATA_W-1:0]                 scalar,
  input  logic [$clog2(MAXBEATS+1)-1:0]     nbeats,
  output logic                              busy,
  output logic                              err,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*DATA_W-1:0]           val_a,
  input  logic [LANES*DATA_W-1:0]           val_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*DATA_W-1:0]           resultado,
  output logic                              out_last,
  output logic                              done
);

  localparam int              NB_W = $clog2(MAXBEATS + 1);
  localparam logic [NB_W-1:0] MAXB = NB_W'(MAXBEATS);

  state_t                   state, state_n;
  logic [3:0]               op_q;
  logic [DATA_W-1:0]        s_q;
  logic [NB_W-1:0]          nb_q;
  logic [NB_W-1:0]          cnt;
  logic                     done_zero;
  logic [LANES*DATA_W-1:0]  alu_y;

  logic cmd_ok;
  logic start_ok;
  logic run_go;
  logic in_fire;
  logic last_in;
  logic last_out;

  always_comb begin
    cmd_ok   = op_legal(opcode) && (nbeats <= MAXB);
    start_ok = (state == IDLE) && start && cmd_ok;
    run_go   = start_ok && (nbeats != '0);
    in_ready = (state == RUN) && (!out_valid || out_ready);
    in_fire  = in_valid && in_ready;
    last_in  = (cnt == nb_q - NB_W'(1));
    last_out = out_valid && out_ready && out_last;
    busy     = (state != IDLE);
    done     = last_out || done_zero;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run_go)             state_n = RUN;
      RUN:     if (in_fire && last_in) state_n = DRAIN;
      DRAIN:   if (last_out)           state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      s_q       <= '0;
      nb_q      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      done_zero <= 1'b0;
    end else begin
      state     <= state_n;
      err       <= (state == IDLE) && start && !cmd_ok;
      done_zero <= start_ok && (nbeats == '0);
      if (run_go) begin
        op_q <= opcode;
        s_q  <= scalar;
        nb_q <= nbeats;
        cnt  <= '0;
      end else if (in_fire) begin
        cnt <= cnt + NB_W'(1);
      end
    end
  end

  // A new beat may load while the previous one is handshaken in the same
  // cycle; otherwise the output register holds until out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      resultado <= alu_y;
      out_valid <= 1'b1;
      out_last  <= last_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .op(op_q),
      .a (val_a[i*DATA_W +: DATA_W]),
      .b (val_b[i*DATA_W +: DATA_W]),
      .s (s_q),
      .y (alu_y[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed bench for vec_alu_pipe (DATA_W=8, LANES=4, MAXBEATS=16) with
// hand-computed expected result lanes.
module tb_vec_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [7:0]  scalar;
  logic [4:0]  nbeats;
  logic        busy, err, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [31:0] val_a, val_b, resultado;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int ov_cnt   = 0;
  logic [31:0] cap_d[$];
  logic        cap_l[$];
  logic [31:0] tb_a[16];
  logic [31:0] tb_b[16];

  vec_alu_pipe #(
    .DATA_W(8),
    .LANES(4),
    .MAXBEATS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .scalar(scalar),
    .nbeats(nbeats), .busy(busy), .err(err), .in_valid(in_valid), .in_ready(in_ready),
    .val_a(val_a), .val_b(val_b), .out_valid(out_valid), .out_ready(out_ready),
    .resultado(resultado), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        cap_d.push_back(resultado);
        cap_l.push_back(out_last);
      end
      if (done) done_cnt++;
      if (out_valid) ov_cnt++;
    end
  end

  task automatic clear_caps();
    cap_d.delete();
    cap_l.delete();
    done_cnt = 0;
    ov_cnt   = 0;
  endtask

  task automatic stream(input logic [3:0] op, input logic [7:0] s, input int nb);
    bit got;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; scalar = s; nbeats = 5'(nb);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < nb; k++) begin
      val_a = tb_a[k]; val_b = tb_b[k]; in_valid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge clk); got = in_ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL stream_in_timeout beat %0d in_ready=0 want 1", k);
      end
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      @(negedge clk); if (!busy) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL stream_drain_timeout busy=1 want 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; opcode = '0; scalar = '0; nbeats = '0;
    in_valid = 1'b0; val_a = '0; val_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, err, in_ready, out_valid, out_last, done, resultado} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, err, in_ready, out_valid, out_last, done, resultado});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_add_vv();
    clear_caps();
    tb_a[0] = 32'hFFFF_FFFF; tb_a[1] = 32'hFFFF_FFFF;
    tb_b[0] = 32'h0202_0202; tb_b[1] = 32'h0202_0202;
    stream(4'b0001, 8'h00, 2);
    n_tests++;
    if (cap_d.size() != 2) begin n_fail++; $display("FAIL add_count got %0d want 2", cap_d.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (cap_d[k] !== 32'h0101_0101) begin
          n_fail++; $display("FAIL add_beat%0d got %h want 01010101", k, cap_d[k]);
        end
        n_tests++;
        if (cap_l[k] !== (k == 1)) begin
          n_fail++; $display("FAIL add_last%0d got %b want %b", k, cap_l[k], (k == 1));
        end
      end
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL add_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_shift_rotate();
    logic [3:0]  ops[8]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b0110, 4'b0110, 4'b0111, 4'b0111};
    logic [7:0]  ss[8]   = '{8'd3, 8'd8, 8'd11, 8'd3, 8'd9, 8'd1, 8'd4, 8'd8};
    logic [31:0] as[8]   = '{32'h8181_8181, 32'h8181_8181, 32'h8181_8181, 32'h8181_8181,
                             32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
    logic [31:0] exps[8] = '{32'h0C0C_0C0C, 32'h8181_8181, 32'h0C0C_0C0C, 32'h3030_3030,
                             32'h0000_0000, 32'h5454_5454, 32'h0A0A_0A0A, 32'h0000_0000};
    for (int t = 0; t < 8; t++) begin
      clear_caps();
      tb_a[0] = as[t]; tb_b[0] = 32'h5A5A_5A5A;
      stream(ops[t], ss[t], 1);
      n_tests++;
      if (cap_d.size() != 1) begin
        n_fail++; $display("FAIL shrot%0d_count got %0d want 1", t, cap_d.size());
      end else begin
        n_tests++;
        if (cap_d[0] !== exps[t]) begin
          n_fail++; $display("FAIL shrot%0d op %b s %0d got %h want %h", t, ops[t], ss[t], cap_d[0], exps[t]);
        end
      end
    end
  endtask

  task automatic test_misc_ops();
    logic [3:0]  ops[6]  = '{4'b0000, 4'b0010, 4'b0101, 4'b1011, 4'b1111, 4'b1010};
    logic [7:0]  ss[6]   = '{8'h00, 8'h00, 8'hFF, 8'h10, 8'h90, 8'h01};
    logic [31:0] exps[6] = '{32'h8142_FFFF, 32'h7F3E_E11F, 32'h7FBF_0FF0,
                             32'h7030_E0FF, 32'h10D0_809F, 32'h8141_F110};
    for (int t = 0; t < 6; t++) begin
      clear_caps();
      tb_a[0] = 32'h8040_F00F; tb_b[0] = 32'h0102_0FF0;
      stream(ops[t], ss[t], 1);
      n_tests++;
      if (cap_d.size() != 1) begin
        n_fail++; $display("FAIL misc%0d_count got %0d want 1", t, cap_d.size());
      end else begin
        n_tests++;
        if (cap_d[0] !== exps[t]) begin
          n_fail++; $display("FAIL misc%0d op %b got %h want %h", t, ops[t], cap_d[0], exps[t]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap;
    clear_caps();
    for (int k = 0; k < 6; k++) begin
      tb_a[k] = {4{8'(k)}};
      tb_b[k] = 32'h1010_1010;
    end
    fork
      stream(4'b0001, 8'h00, 6);
      begin
        for (int w = 0; w < 40 && cap_d.size() < 2; w++) @(negedge clk);
        if (cap_d.size() < 2) begin
          n_tests++; n_fail++; $display("FAIL bp_wait_timeout got %0d beats want 2", cap_d.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b1; opcode = 4'b0011;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (i == 0) snap = resultado;
          n_tests++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
          n_tests++;
          if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid%0d got %b want 1", i, out_valid); end
          n_tests++;
          if (err !== 1'b0) begin n_fail++; $display("FAIL bp_busy_start_err%0d got %b want 0", i, err); end
          if (i > 0) begin
            n_tests++;
            if (resultado !== snap) begin n_fail++; $display("FAIL bp_stable%0d got %h want %h", i, resultado, snap); end
          end
          @(posedge clk); #1;
          if (i == 0) start = 1'b0;
        end
        out_ready = 1'b1;
      end
    join
    n_tests++;
    if (cap_d.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", cap_d.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (cap_d[k] !== {4{8'(k + 16)}}) begin
          n_fail++; $display("FAIL bp_beat%0d got %h want %h", k, cap_d[k], {4{8'(k + 16)}});
        end
        n_tests++;
        if (cap_l[k] !== (k == 5)) begin
          n_fail++; $display("FAIL bp_last%0d got %b want %b", k, cap_l[k], (k == 5));
        end
      end
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_illegal_zero();
    logic [3:0] ops[2] = '{4'b0011, 4'b0001};
    logic [4:0] nbs[2] = '{5'd1, 5'd17};
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      start = 1'b1; opcode = ops[t]; nbeats = nbs[t]; in_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL err%0d_pulse got %b want 1", t, err); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL err%0d_busy got %b want 0", t, busy); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL err%0d_in_ready got %b want 0", t, in_ready); end
      @(posedge clk); #1;
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err%0d_clear got %b want 0", t, err); end
      in_valid = 1'b0;
    end
    clear_caps();
    @(posedge clk); #1;
    start = 1'b1; opcode = 4'b0001; nbeats = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_clear got %b want 0", done); end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (ov_cnt != 0) begin n_fail++; $display("FAIL zero_out_valid got %0d cycles want 0", ov_cnt); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start = 1'b1; opcode = 4'b0001; nbeats = 5'd4;
    @(posedge clk); #1;
    start = 1'b0; val_a = 32'h0101_0101; val_b = 32'h0101_0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_latency_valid got %b want 1", out_valid); end
    n_tests++;
    if (resultado !== 32'h0202_0202) begin n_fail++; $display("FAIL ar_beat0 got %h want 02020202", resultado); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_before got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, err, in_ready, out_valid, out_last, done, resultado} !== 38'd0) begin
      n_fail++;
      $display("FAIL ar_async_clear got %h want 0",
               {busy, err, in_ready, out_valid, out_last, done, resultado});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_idle_after got %b want 0", busy); end
    clear_caps();
    tb_a[0] = 32'h0505_0505; tb_b[0] = 32'h0303_0303;
    stream(4'b0001, 8'h00, 1);
    n_tests++;
    if (cap_d.size() != 1) begin n_fail++; $display("FAIL ar_rerun_count got %0d want 1", cap_d.size()); end
    else begin
      n_tests++;
      if (cap_d[0] !== 32'h0808_0808) begin n_fail++; $display("FAIL ar_rerun got %h want 08080808", cap_d[0]); end
      n_tests++;
      if (cap_l[0] !== 1'b1) begin n_fail++; $display("FAIL ar_rerun_last got %b want 1", cap_l[0]); end
    end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL ar_rerun_done got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_add_vv();
    test_shift_rotate();
    test_misc_ops();
    test_backpressure();
    test_illegal_zero();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
